// File: rtl/cv32e40p_instr_obi_responder.sv
// cv32e40p_instr_obi_responder: OBI instruction-fetch responder backed by a synchronous word memory.
//
// Ports:
//   clk, rst            single rising-edge clock, synchronous active-high reset
//   instr_req_i         fetch request from the IF stage
//   instr_addr_i        fetch byte address (bits [1:0] ignored, word fetch)
//   instr_gnt_o         address phase accepted (combinational)
//   instr_rvalid_o      response valid, exactly RESP_LATENCY cycles after its grant
//   instr_rdata_o       response word, zero while instr_rvalid_o is low
//   instr_err_o         response is a bus error, zero while instr_rvalid_o is low
//   stall_i             suppresses granting
//   mem_req_o           synchronous memory read enable
//   mem_addr_o          memory word index
//   mem_rdata_i         memory read data, valid the cycle after mem_req_o
//
// Optional feature: define CV32E40P_INSTR_RESP_ERR_EN to answer out-of-range
// fetches with an error response instead of wrapping the word index.
module cv32e40p_instr_obi_responder #(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned RESP_LATENCY    = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         instr_req_i,
    input  logic [31:0]                  instr_addr_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    output logic [31:0]                  instr_rdata_o,
    output logic                         instr_err_o,
    input  logic                         stall_i,
    output logic                         mem_req_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    input  logic [31:0]                  mem_rdata_i
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic [31:0]             off;
    logic [2:0]              cnt_q, cnt_d;
    logic [RESP_LATENCY-1:0] v_q;
    logic [31:0]             resp_data;
    logic                    rv, gnt, resp_err;

    assign off = instr_addr_i - BASE_ADDR;
    // Gating with rst keeps every output quiet during the reset cycle itself.
    assign rv  = v_q[RESP_LATENCY-1] & ~rst;
    // A retiring response frees its slot in the same cycle, so a full window can still grant.
    assign gnt = instr_req_i & ~stall_i & ~rst & ((cnt_q < 3'(MAX_OUTSTANDING)) | rv);
    assign cnt_d = cnt_q + {2'b00, gnt} - {2'b00, rv};

`ifdef CV32E40P_INSTR_RESP_ERR_EN
    logic                    in_range;
    logic [RESP_LATENCY-1:0] e_q;

    assign in_range  = off[31:AW+2] == '0;
    assign mem_req_o = gnt & in_range;
    assign resp_err  = e_q[RESP_LATENCY-1];

    // Error flag travels alongside the valid bit; it is only observed when valid.
    always_ff @(posedge clk) begin
        e_q[0] <= gnt & ~in_range;
        for (int k = 1; k < int'(RESP_LATENCY); k++) e_q[k] <= e_q[k-1];
    end
`else
    assign mem_req_o = gnt;
    assign resp_err  = 1'b0;
`endif

    assign mem_addr_o     = mem_req_o ? off[AW+1:2] : '0;
    assign instr_gnt_o    = gnt;
    assign instr_rvalid_o = rv;
    assign instr_err_o    = rv & resp_err;
    assign instr_rdata_o  = (rv & ~resp_err) ? resp_data : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            v_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            v_q[0] <= gnt;
            for (int k = 1; k < int'(RESP_LATENCY); k++) v_q[k] <= v_q[k-1];
        end
    end

    // Memory data arrives one cycle after the grant, which is already the
    // response cycle at latency 1; longer latencies delay it further.
    generate
        if (RESP_LATENCY == 1) begin : g_direct
            assign resp_data = mem_rdata_i;
        end else begin : g_pipe
            logic [31:0] d_q [RESP_LATENCY-1];
            always_ff @(posedge clk) begin
                d_q[0] <= mem_rdata_i;
                for (int k = 1; k < int'(RESP_LATENCY) - 1; k++) d_q[k] <= d_q[k-1];
            end
            assign resp_data = d_q[RESP_LATENCY-2];
        end
    endgenerate
endmodule

// File: doc/cv32e40p_instr_obi_responder.md
CV32E40P_INSTR_OBI_RESPONDER -- requirements
Module: cv32e40p_instr_obi_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, backing-memory depth in 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0 (MEM_WORDS*4 aligned).
REQ-003 SHALL have parameter RESP_LATENCY, default 1, grant-to-rvalid cycles (1..4).
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, maximum granted-but-unanswered requests (1..4).
REQ-005 SHALL have port clk input 1: single clock, all logic on its rising edge.
REQ-006 SHALL have port rst input 1: reset, synchronous and active-high.
REQ-007 SHALL have port instr_req_i input 1: fetch request from the IF-stage initiator.
REQ-008 SHALL have port instr_addr_i input 32: fetch byte address.
REQ-009 SHALL have port instr_gnt_o output 1: address phase accepted.
REQ-010 SHALL have port instr_rvalid_o output 1: response valid, one cycle per grant.
REQ-011 SHALL have port instr_rdata_o output 32: response word.
REQ-012 SHALL have port instr_err_o output 1: response is a bus error (valid with instr_rvalid_o).
REQ-013 SHALL have port stall_i input 1: suppresses granting (bench backpressure).
REQ-014 SHALL have port mem_req_o output 1: synchronous memory read enable.
REQ-015 SHALL have port mem_addr_o output $clog2(MEM_WORDS): word index.
REQ-016 SHALL have port mem_rdata_i input 32: read data, valid the cycle after mem_req_o.

Function
REQ-017 instr_gnt_o SHALL be combinational: instr_req_i & ~stall_i & ~rst & (outstanding < MAX_OUTSTANDING | instr_rvalid_o).
REQ-018 outstanding counter SHALL increment on grant, decrement on rvalid, hold on both/neither; it SHALL never exceed MAX_OUTSTANDING nor underflow.
REQ-019 A request granted in cycle t SHALL produce instr_rvalid_o high in cycle t+RESP_LATENCY exactly; rvalid SHALL never coincide with its own grant.
REQ-020 Responses SHALL return in grant order; back-to-back grants SHALL yield back-to-back rvalids.
REQ-021 On a legal grant, mem_req_o SHALL be high in the grant cycle with mem_addr_o = (instr_addr_i - BASE_ADDR) >> 2; otherwise mem_req_o low.
REQ-022 instr_rdata_o SHALL equal mem_rdata_i sampled the cycle after mem_req_o, held in the latency pipeline; instr_addr_i[1:0] ignored (word fetch).
REQ-023 Response pipeline SHALL be RESP_LATENCY stages carrying {valid, err, data}; no rready exists, so the initiator always consumes rvalid.
REQ-024 When instr_rvalid_o is low, instr_rdata_o and instr_err_o SHALL be 0.
REQ-025 instr_req_i deasserted before grant SHALL be allowed (no state change); address changes while ungranted SHALL be honoured at grant time.
REQ-026 Simultaneous grant and rvalid at outstanding == MAX_OUTSTANDING SHALL be permitted, keeping outstanding unchanged.

Reset
REQ-027 While rst high at a clk edge: outstanding=0, all pipeline stages invalid; outputs instr_gnt_o=0, instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0, mem_req_o=0, mem_addr_o=0.
REQ-028 rst asserted mid-operation SHALL discard all in-flight responses; no rvalid SHALL appear after rst deasserts for pre-reset grants.

Configuration
REQ-029 Macro CV32E40P_INSTR_RESP_ERR_EN: when defined, addresses outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*4) SHALL be granted with mem_req_o=0 and answered after RESP_LATENCY with instr_err_o=1, instr_rdata_o=0.
REQ-030 When CV32E40P_INSTR_RESP_ERR_EN is undefined, the word index SHALL wrap modulo MEM_WORDS, every grant SHALL access memory, and instr_err_o SHALL be tied 0.

Verification
REQ-031 Defaults; req at 0x0000_0010 one cycle, mem[4]=0x0000_0013 -> gnt same cycle, mem_addr_o=4, rvalid next cycle with rdata 0x0000_0013, err 0.
REQ-032 Defaults; req held high 6 cycles, addresses 0x0,0x4,...,0x14 -> 6 grants, 6 consecutive rvalids in order, outstanding never >1.
REQ-033 RESP_LATENCY=3, MAX_OUTSTANDING=2; continuous req -> grants in cycles 0,1, none in 2, resumes in 3 with rvalid; rvalids at 3,4,... in order.
REQ-034 stall_i high 3 cycles while req high -> gnt low for 3 cycles, no mem_req_o, address granted on 4th cycle.
REQ-035 ERR_EN defined, MEM_WORDS=1024, req at 0x0000_1000 -> gnt, mem_req_o 0, rvalid with err 1, rdata 0; undefined -> mem_addr_o=0, err 0.
REQ-036 RESP_LATENCY=2, rst pulsed one cycle after a grant -> no rvalid thereafter, all outputs 0 during reset, outstanding 0.
